// File: rtl/fifo_mode.sv
// fifo_mode: single-clock synchronous FIFO on synchronous-read block storage.
//
// Read modes:
//   SHOWAHEAD=1 : the head word is prefetched and presented on q_o while
//                 empty_o=0; rdreq_i acknowledges (pops) it.
//   SHOWAHEAD=0 : rdreq_i requests a word; q_o carries it one cycle later
//                 (two with REGISTER_OUTPUT=1) and holds it until the next read.
//
// Handshake: a write is accepted when wrreq_i && !full_o, a read when
// rdreq_i && !empty_o, both judged on the flag values before the clock edge.
// A rejected write sets overflow_o, a rejected read sets underflow_o. Both
// flags are sticky until srst_ni.
//
// Ports:
//   clk_i          clock, rising edge
//   srst_ni        synchronous reset, active low, dominates everything
//   clr_i          synchronous flush; like reset but keeps the sticky flags
//   data_i/wrreq_i write data / write request
//   rdreq_i        read request (normal) or acknowledge (showahead)
//   q_o            read data
//   usedw_o        accepted, not yet read words (0..2**AWIDTH)
//   empty_o        registered "q_o valid / read permitted"
//   full_o, almost_full_o, almost_empty_o   decoded from usedw_o
//   overflow_o, underflow_o                 sticky error flags
module fifo_mode #(
  parameter int DWIDTH             = 8,
  parameter int AWIDTH             = 4,
  parameter int ALMOST_FULL_VALUE  = 12,
  parameter int ALMOST_EMPTY_VALUE = 4,
  parameter int SHOWAHEAD          = 1,
  parameter int REGISTER_OUTPUT    = 0
) (
  input  logic              clk_i,
  input  logic              srst_ni,
  input  logic              clr_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int              DEPTH   = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_W    = (AWIDTH+1)'(ALMOST_FULL_VALUE);
  localparam logic [AWIDTH:0] AE_W    = (AWIDTH+1)'(ALMOST_EMPTY_VALUE);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   usedw_q;
  logic [AWIDTH:0]   usedw_nxt;
  logic              wr_acc;
  logic              rd_acc;
  logic              mem_we;

  assign wr_acc    = wrreq_i && !full_o;
  assign rd_acc    = rdreq_i && !empty_o;
  assign usedw_nxt = usedw_q + (AWIDTH+1)'(wr_acc) - (AWIDTH+1)'(rd_acc);

  assign usedw_o        = usedw_q;
  assign full_o         = (usedw_q == DEPTH_W);
  assign almost_full_o  = (usedw_q >= AF_W);
  assign almost_empty_o = (usedw_q < AE_W);

  // Occupancy, write pointer and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      usedw_q     <= '0;
      wr_ptr      <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clr_i) begin
      usedw_q <= '0;
      wr_ptr  <= '0;
    end else begin
      usedw_q <= usedw_nxt;
      if (mem_we) wr_ptr <= wr_ptr + AWIDTH'(1);
      if (wrreq_i && full_o) overflow_o <= 1'b1;
      if (rdreq_i && empty_o) underflow_o <= 1'b1;
    end
  end

  // Block storage, write port.
  always_ff @(posedge clk_i) begin
    if (srst_ni && !clr_i && mem_we) mem[wr_ptr] <= data_i;
  end

  if (SHOWAHEAD != 0) begin : g_showahead
    // Elastic prefetch chain: stage 0 is the storage read register, the last
    // stage drives q_o. A stage advances when the next one is free or is
    // itself advancing, so back-to-back pops see no bubble.
    localparam int NST = (REGISTER_OUTPUT != 0) ? 3 : 2;
    // Stage that may capture data_i directly (write bypass).
    localparam int BT  = NST - 2;

    logic [NST-1:0]    sv;
    logic [NST-1:0]    adv;
    logic [DWIDTH-1:0] sq [NST];
    logic [AWIDTH:0]   mem_cnt;   // words in storage, not yet prefetched
    logic              fetch;
    logic              byp;
    logic              ahead_clear;

    always_comb begin
      logic a;
      adv = '0;
      a = sv[NST-1] && rd_acc;
      adv[NST-1] = a;
      for (int i = NST - 2; i >= 0; i--) begin
        a = sv[i] && (!sv[i+1] || a);
        adv[i] = a;
      end
      ahead_clear = 1'b1;
      for (int i = 0; i < BT; i++) ahead_clear = ahead_clear && !sv[i];
      fetch = (mem_cnt != '0) && (!sv[0] || adv[0]);
      // With the output stage occupied and nothing queued behind it, a new
      // word would otherwise spend a cycle in storage and starve the output
      // during sustained read+write; it is captured straight into the stage
      // just before the output instead. Order holds because nothing older
      // is waiting upstream of that stage.
      byp = wr_acc && sv[NST-1] && (mem_cnt == '0) && ahead_clear &&
            (!sv[BT] || adv[BT]);
    end

    assign mem_we  = wr_acc && !byp;
    assign empty_o = !sv[NST-1];
    assign q_o     = sq[NST-1];

    always_ff @(posedge clk_i) begin
      if (!srst_ni || clr_i) begin
        rd_ptr  <= '0;
        mem_cnt <= '0;
        sv      <= '0;
        for (int i = 0; i < NST; i++) sq[i] <= '0;
      end else begin
        mem_cnt <= mem_cnt + (AWIDTH+1)'(mem_we) - (AWIDTH+1)'(fetch);
        if (fetch) begin
          rd_ptr <= rd_ptr + AWIDTH'(1);
          sq[0]  <= mem[rd_ptr];
        end else if (byp && BT == 0) begin
          sq[0]  <= data_i;
        end
        sv[0] <= fetch || (byp && BT == 0) || (sv[0] && !adv[0]);
        for (int i = 1; i < NST; i++) begin
          if (adv[i-1]) sq[i] <= sq[i-1];
          else if (byp && i == BT) sq[i] <= data_i;
          sv[i] <= adv[i-1] || (byp && i == BT) || (sv[i] && !adv[i]);
        end
      end
    end
  end else begin : g_normal
    logic [DWIDTH-1:0] ram_q;
    logic [DWIDTH-1:0] q1;
    logic              v1;
    logic              empty_r;

    assign mem_we  = wr_acc;
    assign empty_o = empty_r;

    // Read at edge M lands in ram_q, then q1 at M+1; q1 only loads on a
    // completed read so q_o holds between reads.
    always_ff @(posedge clk_i) begin
      if (!srst_ni || clr_i) begin
        rd_ptr  <= '0;
        ram_q   <= '0;
        q1      <= '0;
        v1      <= 1'b0;
        empty_r <= 1'b1;
      end else begin
        empty_r <= (usedw_nxt == '0);
        v1      <= rd_acc;
        if (rd_acc) begin
          ram_q  <= mem[rd_ptr];
          rd_ptr <= rd_ptr + AWIDTH'(1);
        end
        if (v1) q1 <= ram_q;
      end
    end

    if (REGISTER_OUTPUT != 0) begin : g_oreg
      logic [DWIDTH-1:0] q2;
      logic              v2;
      always_ff @(posedge clk_i) begin
        if (!srst_ni || clr_i) begin
          q2 <= '0;
          v2 <= 1'b0;
        end else begin
          v2 <= v1;
          if (v2) q2 <= q1;
        end
      end
      assign q_o = q2;
    end else begin : g_noreg
      assign q_o = q1;
    end
  end

endmodule

// File: tb/tb_fifo_mode.sv
// Bench for fifo_mode: three instances (showahead, showahead with output
// register, normal mode with output register), depth 4, byte data.
module tb_fifo_mode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst_n, clr;
  logic [7:0] a_data, n_data;
  logic       a_wr, a_rd, n_wr, n_rd;

  logic [7:0] sa_q, sr_q, nm_q;
  logic [2:0] sa_usedw, sr_usedw, nm_usedw;
  logic sa_empty, sa_full, sa_af, sa_ae, sa_ovf, sa_unf;
  logic sr_empty, sr_full, sr_af, sr_ae, sr_ovf, sr_unf;
  logic nm_empty, nm_full, nm_af, nm_ae, nm_ovf, nm_unf;

  int total = 0;
  int bad   = 0;

  // Reference for the shared showahead stream.
  logic [7:0] exp_q[$];
  logic       a_ovf_m = 1'b0, a_unf_m = 1'b0;
  // Reference for the normal-mode instance.
  logic [7:0] n_exp_q[$];
  logic       n_ovf_m = 1'b0, n_unf_m = 1'b0;
  logic [7:0] n_q_exp = 8'h00, d1 = 8'h00, d2 = 8'h00;
  logic       d1v = 1'b0, d2v = 1'b0;

  fifo_mode #(.DWIDTH(8), .AWIDTH(2), .ALMOST_FULL_VALUE(3), .ALMOST_EMPTY_VALUE(1),
              .SHOWAHEAD(1), .REGISTER_OUTPUT(0)) u_sa (
    .clk_i(clk), .srst_ni(srst_n), .clr_i(clr), .data_i(a_data), .wrreq_i(a_wr),
    .rdreq_i(a_rd), .q_o(sa_q), .usedw_o(sa_usedw), .empty_o(sa_empty),
    .full_o(sa_full), .almost_full_o(sa_af), .almost_empty_o(sa_ae),
    .overflow_o(sa_ovf), .underflow_o(sa_unf));

  fifo_mode #(.DWIDTH(8), .AWIDTH(2), .ALMOST_FULL_VALUE(3), .ALMOST_EMPTY_VALUE(1),
              .SHOWAHEAD(1), .REGISTER_OUTPUT(1)) u_sr (
    .clk_i(clk), .srst_ni(srst_n), .clr_i(clr), .data_i(a_data), .wrreq_i(a_wr),
    .rdreq_i(a_rd), .q_o(sr_q), .usedw_o(sr_usedw), .empty_o(sr_empty),
    .full_o(sr_full), .almost_full_o(sr_af), .almost_empty_o(sr_ae),
    .overflow_o(sr_ovf), .underflow_o(sr_unf));

  fifo_mode #(.DWIDTH(8), .AWIDTH(2), .ALMOST_FULL_VALUE(3), .ALMOST_EMPTY_VALUE(1),
              .SHOWAHEAD(0), .REGISTER_OUTPUT(1)) u_nm (
    .clk_i(clk), .srst_ni(srst_n), .clr_i(clr), .data_i(n_data), .wrreq_i(n_wr),
    .rdreq_i(n_rd), .q_o(nm_q), .usedw_o(nm_usedw), .empty_o(nm_empty),
    .full_o(nm_full), .almost_full_o(nm_af), .almost_empty_o(nm_ae),
    .overflow_o(nm_ovf), .underflow_o(nm_unf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Occupancy and flag checks of both showahead instances against the model.
  task automatic a_flags(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, " sa usedw"}, 32'(sa_usedw), 32'(n));
    chk({tag, " sr usedw"}, 32'(sr_usedw), 32'(n));
    chk({tag, " sa full"},  32'(sa_full),  32'(n == 4));
    chk({tag, " sr full"},  32'(sr_full),  32'(n == 4));
    chk({tag, " sa afull"}, 32'(sa_af),    32'(n >= 3));
    chk({tag, " sr afull"}, 32'(sr_af),    32'(n >= 3));
    chk({tag, " sa aempty"}, 32'(sa_ae),   32'(n < 1));
    chk({tag, " sr aempty"}, 32'(sr_ae),   32'(n < 1));
    chk({tag, " sa ovf"},   32'(sa_ovf),   32'(a_ovf_m));
    chk({tag, " sr ovf"},   32'(sr_ovf),   32'(a_ovf_m));
    chk({tag, " sa unf"},   32'(sa_unf),   32'(a_unf_m));
    chk({tag, " sr unf"},   32'(sr_unf),   32'(a_unf_m));
  endtask

  // One cycle on the showahead pair. rd=1 means the caller expects the head
  // to be visible, so the head word is checked before it is popped.
  task automatic a_step(input logic wr, input logic rd, input logic [7:0] d);
    logic wacc;
    if (rd) begin
      chk("sa head valid", 32'(sa_empty), 32'(0));
      chk("sr head valid", 32'(sr_empty), 32'(0));
      chk("sa head data", 32'(sa_q), 32'(exp_q[0]));
      chk("sr head data", 32'(sr_q), 32'(exp_q[0]));
    end
    wacc = wr && (exp_q.size() < 4);
    if (wr && exp_q.size() == 4) a_ovf_m = 1'b1;
    a_wr = wr; a_rd = rd; a_data = d;
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    if (rd) void'(exp_q.pop_front());
    if (wacc) exp_q.push_back(d);
  endtask

  // One cycle on the normal-mode instance with full output checking.
  // q_o shows the word popped two edges earlier and otherwise holds.
  task automatic nm_step(input logic wr, input logic rd, input logic [7:0] d);
    logic       wacc, racc;
    logic [7:0] popv;
    int         n;
    racc = rd && (n_exp_q.size() > 0);
    wacc = wr && (n_exp_q.size() < 4);
    if (wr && n_exp_q.size() == 4) n_ovf_m = 1'b1;
    if (rd && n_exp_q.size() == 0) n_unf_m = 1'b1;
    popv = racc ? n_exp_q[0] : 8'h00;
    n_wr = wr; n_rd = rd; n_data = d;
    tick();
    n_wr = 1'b0; n_rd = 1'b0;
    if (racc) void'(n_exp_q.pop_front());
    if (wacc) n_exp_q.push_back(d);
    if (d2v) n_q_exp = d2;
    d2v = d1v; d2 = d1; d1v = racc; d1 = popv;
    n = n_exp_q.size();
    chk("nm q", 32'(nm_q), 32'(n_q_exp));
    chk("nm usedw", 32'(nm_usedw), 32'(n));
    chk("nm empty", 32'(nm_empty), 32'(n == 0));
    chk("nm full", 32'(nm_full), 32'(n == 4));
    chk("nm afull", 32'(nm_af), 32'(n >= 3));
    chk("nm aempty", 32'(nm_ae), 32'(n < 1));
    chk("nm ovf", 32'(nm_ovf), 32'(n_ovf_m));
    chk("nm unf", 32'(nm_unf), 32'(n_unf_m));
  endtask

  task automatic n_flush_model();
    n_exp_q.delete();
    d1v = 1'b0; d2v = 1'b0;
    n_q_exp = 8'h00;
  endtask

  initial begin
    srst_n = 1'b0; clr = 1'b0;
    a_wr = 1'b0; a_rd = 1'b0; a_data = 8'h00;
    n_wr = 1'b0; n_rd = 1'b0; n_data = 8'h00;
    tick(); tick();
    srst_n = 1'b1;
    tick();

    // Reset state.
    a_flags("reset");
    chk("reset sa empty", 32'(sa_empty), 32'(1));
    chk("reset sr empty", 32'(sr_empty), 32'(1));
    chk("reset sa q", 32'(sa_q), 32'(0));
    chk("reset sr q", 32'(sr_q), 32'(0));
    nm_step(1'b0, 1'b0, 8'h00);

    // Fill to full, overflow, then drain in order.
    a_step(1'b1, 1'b0, 8'h11);
    a_step(1'b1, 1'b0, 8'h22);
    a_step(1'b1, 1'b0, 8'h33);
    a_step(1'b1, 1'b0, 8'h44);
    a_flags("fill");
    a_step(1'b1, 1'b0, 8'h55);
    a_flags("overflow");
    for (int i = 0; i < 4; i++) a_step(1'b0, 1'b1, 8'h00);
    a_flags("drain");
    chk("drain sa empty", 32'(sa_empty), 32'(1));
    chk("drain sr empty", 32'(sr_empty), 32'(1));

    // Showahead first-word latency.
    a_step(1'b1, 1'b0, 8'hA5);
    chk("lat N sa empty", 32'(sa_empty), 32'(1));
    chk("lat N sr empty", 32'(sr_empty), 32'(1));
    tick();
    chk("lat N+1 sa empty", 32'(sa_empty), 32'(1));
    chk("lat N+1 sr empty", 32'(sr_empty), 32'(1));
    tick();
    chk("lat N+2 sa empty", 32'(sa_empty), 32'(0));
    chk("lat N+2 sa q", 32'(sa_q), 32'(8'hA5));
    chk("lat N+2 sr empty", 32'(sr_empty), 32'(1));
    tick();
    chk("lat N+3 sr empty", 32'(sr_empty), 32'(0));
    chk("lat N+3 sr q", 32'(sr_q), 32'(8'hA5));
    a_step(1'b0, 1'b1, 8'h00);
    chk("pop sa empty", 32'(sa_empty), 32'(1));
    chk("pop sr empty", 32'(sr_empty), 32'(1));
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    a_unf_m = 1'b1;
    a_flags("underflow");

    // Normal mode read latency and hold on underflow.
    nm_step(1'b1, 1'b0, 8'h5A);
    chk("nm write empty", 32'(nm_empty), 32'(0));
    nm_step(1'b0, 1'b1, 8'h00);
    chk("nm read M q", 32'(nm_q), 32'(8'h00));
    nm_step(1'b0, 1'b0, 8'h00);
    chk("nm read M+1 q", 32'(nm_q), 32'(8'h00));
    nm_step(1'b0, 1'b0, 8'h00);
    chk("nm read M+2 q", 32'(nm_q), 32'(8'h5A));
    nm_step(1'b0, 1'b1, 8'h00);
    chk("nm unf", 32'(nm_unf), 32'(1));
    nm_step(1'b0, 1'b0, 8'h00);
    nm_step(1'b0, 1'b0, 8'h00);
    chk("nm q hold", 32'(nm_q), 32'(8'h5A));

    // Normal mode random traffic, write-heavy then read-heavy.
    for (int i = 0; i < 30; i++)
      nm_step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), 8'($urandom));
    for (int i = 0; i < 30; i++)
      nm_step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0), 8'($urandom));
    for (int i = 0; i < 6; i++) nm_step(1'b1, 1'b0, 8'($urandom));

    // Showahead: full with both requests, then sustained read+write at half.
    for (int i = 0; i < 4; i++) a_step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 3; i++) a_step(1'b0, 1'b0, 8'h00);
    a_step(1'b1, 1'b1, 8'($urandom));
    a_flags("full both");
    a_step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) a_step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 100; i++) begin
      a_step(1'b1, 1'b1, 8'($urandom));
      chk("stream sa usedw", 32'(sa_usedw), 32'(2));
      chk("stream sr usedw", 32'(sr_usedw), 32'(2));
    end
    a_step(1'b0, 1'b1, 8'h00);
    a_step(1'b0, 1'b1, 8'h00);
    a_flags("stream end");

    // Flush keeps sticky flags.
    for (int i = 0; i < 3; i++) a_step(1'b1, 1'b0, 8'($urandom));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
    n_flush_model();
    a_flags("clear");
    chk("clear sa empty", 32'(sa_empty), 32'(1));
    chk("clear sr empty", 32'(sr_empty), 32'(1));
    chk("clear sa q", 32'(sa_q), 32'(0));
    chk("clear sr q", 32'(sr_q), 32'(0));
    nm_step(1'b0, 1'b0, 8'h00);
    a_step(1'b1, 1'b0, 8'h3C);
    a_step(1'b1, 1'b0, 8'hC3);
    a_step(1'b0, 1'b0, 8'h00);
    a_step(1'b0, 1'b0, 8'h00);
    a_step(1'b0, 1'b1, 8'h00);
    a_step(1'b0, 1'b1, 8'h00);

    // Reset mid-stream.
    a_step(1'b1, 1'b0, 8'h77);
    nm_step(1'b1, 1'b0, 8'h88);
    a_wr = 1'b1; n_wr = 1'b1; a_data = 8'h99; n_data = 8'h99;
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1; a_wr = 1'b0; n_wr = 1'b0;
    exp_q.delete();
    a_ovf_m = 1'b0; a_unf_m = 1'b0;
    n_flush_model();
    n_ovf_m = 1'b0; n_unf_m = 1'b0;
    a_flags("midreset");
    chk("midreset sa empty", 32'(sa_empty), 32'(1));
    chk("midreset sr empty", 32'(sr_empty), 32'(1));
    chk("midreset sa q", 32'(sa_q), 32'(0));
    chk("midreset sr q", 32'(sr_q), 32'(0));
    nm_step(1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_mode.md
Name: fifo_mode

Overview:
Single-clock synchronous FIFO with synchronous-read block storage, generalised over data width, depth and read mode.
- Supports both read modes: SHOWAHEAD (first-word fall-through) and normal (data follows the read request).
- Optional output register on q_o.
- Adds sticky overflow/underflow error flags and a synchronous flush.
- Drop-in buffer between streaming stages in the FPGA datapath.

Parameters:
DWIDTH, 8, data word width in bits (>=1)
AWIDTH, 4, address width; depth = 2**AWIDTH words (>=1)
ALMOST_FULL_VALUE, 12, almost_full_o threshold, 1..2**AWIDTH
ALMOST_EMPTY_VALUE, 4, almost_empty_o threshold, 0..2**AWIDTH
SHOWAHEAD, 1, 1 = head word presented on q_o before rdreq_i; 0 = normal mode
REGISTER_OUTPUT, 0, 1 = extra output register stage on q_o

Ports:
clk_i  in  1  clock, all logic on rising edge
srst_ni  in  1  synchronous reset, active-low
clr_i  in  1  synchronous flush, active-high; same effect as reset except sticky flags are kept
data_i  in  DWIDTH  write data
wrreq_i  in  1  write request
rdreq_i  in  1  read request / acknowledge
q_o  out  DWIDTH  read data
usedw_o  out  AWIDTH+1  number of accepted, not yet read words
empty_o  out  1  no word available on the read side
full_o  out  1  usedw_o == 2**AWIDTH
almost_full_o  out  1  usedw_o >= ALMOST_FULL_VALUE
almost_empty_o  out  1  usedw_o < ALMOST_EMPTY_VALUE
overflow_o  out  1  sticky: write attempted while full
underflow_o  out  1  sticky: read attempted while empty

Behaviour:
- Reset (srst_ni=0 at an edge):
  - Pointers, usedw_o, q_o and the prefetch/output registers go to 0.
  - empty_o=1, full_o=0, overflow_o=0, underflow_o=0.
  - almost_empty_o = (ALMOST_EMPTY_VALUE>0); almost_full_o=0.
  - Reset dominates clr_i and all requests. Reset mid-operation discards all contents.
- clr_i=1: same as reset, except overflow_o and underflow_o hold their values. Requests in that cycle are ignored.
- Request acceptance:
  - Write accepted: wr_acc = wrreq_i && !full_o.
  - Read accepted: rd_acc = rdreq_i && !empty_o.
  - Both are evaluated on pre-edge flag values. Full plus both requests: read accepted, write rejected. Empty plus both requests: write accepted, read rejected.
- Rejected requests:
  - wrreq_i && full_o sets overflow_o; storage and pointers are unchanged.
  - rdreq_i && empty_o sets underflow_o.
  - Both flags are cleared only by reset.
- usedw_o:
  - usedw_o <= usedw_o + wr_acc - rd_acc, registered.
  - Range 0..2**AWIDTH. Pointers wrap modulo 2**AWIDTH.
  - Flags full_o, almost_full_o and almost_empty_o are combinational from the registered usedw_o.
- empty_o is registered and means "q_o valid / read permitted". It may lag usedw_o.
- Normal mode (SHOWAHEAD=0):
  - empty_o <= (next usedw == 0), so it deasserts the cycle after the first accepted write.
  - Read accepted at edge M: q_o carries the word after edge M+1 (REGISTER_OUTPUT=0) or after edge M+2 (REGISTER_OUTPUT=1).
  - q_o holds its value when no read is accepted.
- Showahead mode (SHOWAHEAD=1):
  - The head word is prefetched from storage into the read stage.
  - Write accepted into an empty FIFO at edge N: q_o valid and empty_o=0 after edge N+2 (REGISTER_OUTPUT=0) or after edge N+3 (REGISTER_OUTPUT=1).
  - rd_acc at edge M pops the head. If more words are present, the next word is on q_o with empty_o=0 after edge M+1, with no bubble for back-to-back reads in either REGISTER_OUTPUT setting.
  - If no further word is present, empty_o=1 after edge M+1 and q_o is don't-care.
  - A simultaneous write to a FIFO holding one word must not lose or duplicate data.
- Throughput: one write and one read per cycle sustained, including at full and empty boundaries.
- Ordering: strict FIFO order. Every accepted word is read exactly once.

Test Plan:
1. Reset, then idle -> usedw_o=0, empty_o=1, full_o=0, almost_empty_o=1, overflow_o=0, underflow_o=0.
2. DWIDTH=8, AWIDTH=2, showahead: write 0x11..0x44 on consecutive cycles -> full_o=1, usedw_o=4. A 5th write sets overflow_o=1 and usedw_o stays 4. Reads then return 0x11,0x22,0x33,0x44.
3. Showahead: single write 0xA5 at edge N -> q_o=0xA5 with empty_o=0 after edge N+2 (N+3 when REGISTER_OUTPUT=1). rdreq_i for one cycle -> empty_o=1, usedw_o=0.
4. Normal mode: write 0x5A, rdreq_i at edge M -> q_o=0x5A after edge M+1 (M+2 when registered). rdreq_i on empty sets underflow_o=1 and q_o holds 0x5A.
5. Full FIFO, wrreq_i=rdreq_i=1 for one cycle -> read accepted, write rejected, usedw_o=3, overflow_o=1. Half-full, simultaneous requests for 100 cycles with a random scoreboard -> usedw_o constant and order preserved across pointer wrap.
6. Write 3 words, pulse clr_i after an earlier overflow -> usedw_o=0, empty_o=1, overflow_o still 1. srst_ni=0 mid-stream -> all flags at reset values.
